// File: rtl/present80_serial_engine.sv
// PRESENT-80 encryption engine. The S-box layer is applied SBOX_LANES nibbles per cycle.
// Optional build macro PRESENT_ROUND_OUT_EN adds a Round_ob port that shows the round counter.
module present80_serial_engine #(
    parameter int SBOX_LANES = 1
) (
    input  logic        Clk_ik,
    input  logic        Reset_irn,
    input  logic [63:0] PlainText_ib,
    input  logic [79:0] Key_ib,
    input  logic        Start_i,
    output logic [63:0] CipherText_ob,
`ifdef PRESENT_ROUND_OUT_EN
    output logic [4:0]  Round_ob,
`endif
    output logic        Ready_o
);

    localparam int         NIB_CYCLES = 16 / SBOX_LANES;
    localparam logic [3:0] LAST_NIB   = 4'(NIB_CYCLES - 1);

    if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
        SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
        $error("SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SBOX = 2'd1,
        S_PERM = 2'd2
    } fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [63:0] state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  round_q, round_d;
    logic [3:0]  nib_q, nib_d;
    logic [63:0] sbox_state, perm_state;
    logic [79:0] key_rot, key_next;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Nibbles i with i/SBOX_LANES == nib_q are substituted this cycle.
    always_comb begin
        sbox_state = state_q;
        for (int i = 0; i < 16; i++) begin
            if (4'(i / SBOX_LANES) == nib_q) begin
                sbox_state[4*i +: 4] = sbox(state_q[4*i +: 4]);
            end
        end
    end

    always_comb begin
        perm_state     = '0;
        perm_state[63] = state_q[63];
        for (int i = 0; i < 63; i++) begin
            perm_state[6'((16 * i) % 63)] = state_q[i];
        end
    end

    // Rotate left by 61 is the same as rotate right by 19.
    always_comb begin
        key_rot         = {key_q[18:0], key_q[79:19]};
        key_next        = key_rot;
        key_next[79:76] = sbox(key_rot[79:76]);
        key_next[19:15] = key_rot[19:15] ^ round_q;
    end

    // Handshake: Start_i is accepted only on an edge where Ready_o=1. Ready_o then
    // stays 0 until the final round completes; CipherText_ob is valid while Ready_o=1.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        nib_d   = nib_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (Start_i) begin
                    state_d = PlainText_ib ^ Key_ib[79:16];
                    key_d   = Key_ib;
                    round_d = 5'd1;
                    nib_d   = '0;
                    fsm_d   = S_SBOX;
                end
            end
            S_SBOX: begin
                state_d = sbox_state;
                if (nib_q == LAST_NIB) begin
                    nib_d = '0;
                    fsm_d = S_PERM;
                end else begin
                    nib_d = nib_q + 4'd1;
                end
            end
            S_PERM: begin
                state_d = perm_state ^ key_next[79:16];
                key_d   = key_next;
                if (round_q == 5'd31) begin
                    round_d = '0;
                    fsm_d   = S_IDLE;
                end else begin
                    round_d = round_q + 5'd1;
                    fsm_d   = S_SBOX;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_ik or negedge Reset_irn) begin
        if (!Reset_irn) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_ff @(posedge Clk_ik or negedge Reset_irn) begin
        if (!Reset_irn) begin
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
            nib_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            nib_q   <= nib_d;
        end
    end

    assign CipherText_ob = state_q;
    assign Ready_o       = (fsm_q == S_IDLE);
`ifdef PRESENT_ROUND_OUT_EN
    assign Round_ob      = round_q;
`endif

endmodule

// File: tb/tb_present80_serial_engine.sv
// Bench for present80_serial_engine: one instance per legal SBOX_LANES, shared inputs,
// per-lane expected queues drained by a monitor on each rising Ready_o.
module tb_present80_serial_engine;
  localparam int NL = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [63:0] pt;
  logic [79:0] key;
  logic [NL-1:0] start;
  logic [NL-1:0] rdy;
  logic [63:0] ct [NL];
  logic [4:0] rnd [NL];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] exp_q [NL][$];
  int lat_q [NL][$];
  int t0_q [NL][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    present80_serial_engine #(.SBOX_LANES(1 << g)) u_dut (
      .Clk_ik(clk),
      .Reset_irn(rst_n),
      .PlainText_ib(pt),
      .Key_ib(key),
      .Start_i(start[g]),
      .CipherText_ob(ct[g]),
`ifdef PRESENT_ROUND_OUT_EN
      .Round_ob(rnd[g]),
`endif
      .Ready_o(rdy[g])
    );
`ifndef PRESENT_ROUND_OUT_EN
    assign rnd[g] = '0;
`endif
  end

  task automatic chk(input string name, input int lanes, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s lanes=%0d got=%0h expected=%0h", name, lanes, got, exp);
    end
  endtask

  // Monitor: every rising Ready_o outside reset must match the oldest expected run.
  logic [NL-1:0] prev_rdy = '1;
  always @(negedge clk) begin
    for (int g = 0; g < NL; g++) begin
      if (rst_n && rdy[g] && !prev_rdy[g]) begin
        if (exp_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result lanes=%0d got=%0h expected=none", 1 << g, ct[g]);
        end else begin
          logic [63:0] e;
          int lat;
          int t0;
          e = exp_q[g].pop_front();
          lat = lat_q[g].pop_front();
          t0 = t0_q[g].pop_front();
          chk("ciphertext", 1 << g, 80'(ct[g]), 80'(e));
          chk("latency", 1 << g, 80'(cyc - t0), 80'(lat));
        end
      end
    end
    prev_rdy <= rdy;
  end

  // Drives Start_i on selected lanes for one cycle; latency is counted in edges from
  // the negedge that raises Start_i to the edge on which Ready_o rises.
  task automatic start_run(input logic [63:0] p, input logic [79:0] k, input logic [63:0] exp_ct);
    @(negedge clk);
    pt = p;
    key = k;
    for (int g = 0; g < NL; g++) begin
      exp_q[g].push_back(exp_ct);
      lat_q[g].push_back(1 + 31 * (16 / (1 << g) + 1));
      t0_q[g].push_back(cyc);
    end
    start = '1;
    @(negedge clk);
    start = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (rdy !== '1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got=%b expected=%b", rdy, {NL{1'b1}});
    end
    @(negedge clk);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    start = '0;
    pt = '0;
    key = '0;
    #3;
    for (int g = 0; g < NL; g++) begin
      chk("reset_ready", 1 << g, 80'(rdy[g]), 80'(1));
      chk("reset_ct", 1 << g, 80'(ct[g]), 80'(0));
`ifdef PRESENT_ROUND_OUT_EN
      chk("reset_round", 1 << g, 80'(rnd[g]), 80'(0));
`endif
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NL; g++) chk("idle_ready", 1 << g, 80'(rdy[g]), 80'(1));

    start_run(64'h0, 80'h0, 64'h5579C1387B228445);
    wait_idle();
    start_run(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049);
    wait_idle();
    start_run({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B);
    wait_idle();
    start_run({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2);
    wait_idle();

    // Inputs change and a start pulse arrive mid-run; neither may disturb it.
    start_run(64'h0, 80'h0, 64'h5579C1387B228445);
    t0 = cyc - 1;
    pt = {64{1'b1}};
    key = {80{1'b1}};
    while (cyc < t0 + 100) @(negedge clk);
    start = 5'b00111;
    @(negedge clk);
    start = '0;
    for (int g = 0; g < 3; g++) chk("busy_start_ignored", 1 << g, 80'(rdy[g]), 80'(0));
    wait_idle();
    start_run({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2);
    wait_idle();

    // Asynchronous reset mid-run.
    start_run(64'h0, 80'h0, 64'h5579C1387B228445);
    t0 = cyc - 1;
    while (cyc < t0 + 200) @(negedge clk);
    #2;
    for (int g = 0; g < NL; g++) begin
      exp_q[g].delete();
      lat_q[g].delete();
      t0_q[g].delete();
    end
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NL; g++) begin
      chk("async_reset_ready", 1 << g, 80'(rdy[g]), 80'(1));
      chk("async_reset_ct", 1 << g, 80'(ct[g]), 80'(0));
`ifdef PRESENT_ROUND_OUT_EN
      chk("async_reset_round", 1 << g, 80'(rnd[g]), 80'(0));
`endif
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(64'h0, 80'h0, 64'h5579C1387B228445);
`ifdef PRESENT_ROUND_OUT_EN
    for (int g = 0; g < NL; g++) chk("round_after_start", 1 << g, 80'(rnd[g]), 80'(1));
`endif
    wait_idle();

    for (int g = 0; g < NL; g++) chk("queue_drained", 1 << g, 80'(exp_q[g].size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
